// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Write-port controller for a 32-entry register file. After reset
//            it clears x1..x31 to zero, one register per clock. It then shares
//            the single write port between two writeback requesters (A = ALU,
//            B = load) with round-robin arbitration and valid/ready handshakes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   a_valid/a_ready     requester A handshake (a_ready is combinational)
//   a_addr, a_data      requester A destination register and write data
//   b_valid/b_ready     requester B handshake (b_ready is combinational)
//   b_addr, b_data      requester B destination register and write data
//   rf_writeReg         registered register-file write address
//   rf_writeData        registered register-file write data
//   rf_write            registered register-file write enable
//   init_done           clear sequence finished, requests are being serviced
// ============================================================================
module regfile_wb_arbiter #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [4:0]           a_addr,
  input  logic [BUS_WIDTH-1:0] a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [4:0]           b_addr,
  input  logic [BUS_WIDTH-1:0] b_data,
  output logic [4:0]           rf_writeReg,
  output logic [BUS_WIDTH-1:0] rf_writeData,
  output logic                 rf_write,
  output logic                 init_done
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Priority pointer encoding: which side wins when both are valid.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  localparam logic [4:0] LAST_REG = 5'd31;

  state_t               state;
  state_t               state_nxt;
  logic [4:0]           cnt;
  logic [4:0]           cnt_nxt;
  logic                 ptr;
  logic                 ptr_nxt;
  logic                 init_done_nxt;
  logic                 write_nxt;
  logic [4:0]           write_reg_nxt;
  logic [BUS_WIDTH-1:0] write_data_nxt;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CLEAR;
      cnt          <= 5'd1;
      ptr          <= PTR_A;
      init_done    <= 1'b0;
      rf_write     <= 1'b0;
      rf_writeReg  <= 5'd0;
      rf_writeData <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ptr          <= ptr_nxt;
      init_done    <= init_done_nxt;
      rf_write     <= write_nxt;
      rf_writeReg  <= write_reg_nxt;
      rf_writeData <= write_data_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, grant and write-port logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ptr_nxt        = ptr;
    init_done_nxt  = init_done;
    write_nxt      = 1'b0;
    write_reg_nxt  = rf_writeReg;
    write_data_nxt = rf_writeData;
    a_ready        = 1'b0;
    b_ready        = 1'b0;

    unique case (state)
      CLEAR: begin
        // x0 is hardwired zero, so the sweep starts at x1.
        write_nxt      = 1'b1;
        write_reg_nxt  = cnt;
        write_data_nxt = '0;
        cnt_nxt        = cnt + 5'd1;
        if (cnt == LAST_REG) begin
          state_nxt     = RUN;
          init_done_nxt = 1'b1;
        end
      end

      RUN: begin
        // The if/else chain guarantees at most one ready is ever high.
        if (a_valid && (!b_valid || (ptr == PTR_A))) begin
          a_ready = 1'b1;
        end else if (b_valid) begin
          b_ready = 1'b1;
        end

        if (a_ready) begin
          ptr_nxt = PTR_B;
          // A write to x0 still completes the handshake but is discarded.
          if (a_addr != 5'd0) begin
            write_nxt      = 1'b1;
            write_reg_nxt  = a_addr;
            write_data_nxt = a_data;
          end
        end else if (b_ready) begin
          ptr_nxt = PTR_A;
          if (b_addr != 5'd0) begin
            write_nxt      = 1'b1;
            write_reg_nxt  = b_addr;
            write_data_nxt = b_data;
          end
        end
      end

      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter. A small
//            behavioural register file sits on the write port so register
//            contents can be read back after the clear and after transfers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int BUS_WIDTH = 32;

  logic                 clk;
  logic                 rst_n;
  logic                 a_valid;
  logic                 a_ready;
  logic [4:0]           a_addr;
  logic [BUS_WIDTH-1:0] a_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [4:0]           b_addr;
  logic [BUS_WIDTH-1:0] b_data;
  logic [4:0]           rf_writeReg;
  logic [BUS_WIDTH-1:0] rf_writeData;
  logic                 rf_write;
  logic                 init_done;

  int n_total;
  int n_bad;

  // Register file model: x0 reads zero, others power up with a junk pattern
  // so the clear sequence has something to overwrite.
  logic [BUS_WIDTH-1:0] rf_model [0:31];

  regfile_wb_arbiter #(.BUS_WIDTH(BUS_WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .rf_writeReg  (rf_writeReg),
    .rf_writeData (rf_writeData),
    .rf_write     (rf_write),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rf_model[0] = '0;
    for (int r = 1; r < 32; r++) rf_model[r] = 32'hDEAD_0000 | r;
  end

  always @(posedge clk) begin
    if (rf_write && (rf_writeReg != 5'd0)) rf_model[rf_writeReg] <= rf_writeData;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the 31-cycle clear after rst_n release. Requesters held by the caller
  // must see no ready until RUN. If raise_at matches a cycle, A starts a
  // request (addr 7, data 0x55) at that point.
  task automatic run_clear(input int raise_at);
    logic exp_a;
    logic exp_b;
    for (int k = 1; k <= 31; k++) begin
      tick();
      check($sformatf("clr_we_%0d", k), {31'd0, rf_write}, 32'd1);
      check($sformatf("clr_reg_%0d", k), {27'd0, rf_writeReg}, k);
      check($sformatf("clr_dat_%0d", k), rf_writeData, 32'd0);
      if (k >= 30) check($sformatf("clr_done_%0d", k), {31'd0, init_done}, (k == 31) ? 32'd1 : 32'd0);
      if (k == raise_at) begin
        a_valid = 1'b1;
        a_addr  = 5'd7;
        a_data  = 32'h0000_0055;
      end
      #1;
      exp_a = (k == 31) && a_valid;
      exp_b = (k == 31) && b_valid && !a_valid;
      check($sformatf("clr_ardy_%0d", k), {31'd0, a_ready}, {31'd0, exp_a});
      check($sformatf("clr_brdy_%0d", k), {31'd0, b_ready}, {31'd0, exp_b});
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    a_valid = 1'b0;
    a_addr  = '0;
    a_data  = '0;
    b_valid = 1'b0;
    b_addr  = '0;
    b_data  = '0;

    // ---------------- reset state and clear ----------------
    #22;
    check("rst_we",   {31'd0, rf_write}, 32'd0);
    check("rst_reg",  {27'd0, rf_writeReg}, 32'd0);
    check("rst_dat",  rf_writeData, 32'd0);
    check("rst_done", {31'd0, init_done}, 32'd0);
    check("rst_ardy", {31'd0, a_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear(0);
    tick();  // P32: nothing requested
    check("idle_we", {31'd0, rf_write}, 32'd0);
    for (int r = 0; r < 32; r++) check($sformatf("clr_x%0d", r), rf_model[r], 32'd0);

    // ---------------- contention A/B ----------------
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA_0003;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'hBBBB_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("ct_ardy_%0d", i), {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("ct_brdy_%0d", i), {31'd0, b_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("ct_we_%0d", i),  {31'd0, rf_write}, 32'd1);
      check($sformatf("ct_reg_%0d", i), {27'd0, rf_writeReg}, (i % 2 == 0) ? 32'd3 : 32'd4);
      check($sformatf("ct_dat_%0d", i), rf_writeData, (i % 2 == 0) ? 32'hAAAA_0003 : 32'hBBBB_0004);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    check("ct_x3", rf_model[3], 32'hAAAA_0003);
    check("ct_x4", rf_model[4], 32'hBBBB_0004);
    check("ct_idle_we", {31'd0, rf_write}, 32'd0);
    check("ct_hold_reg", {27'd0, rf_writeReg}, 32'd4);

    // ---------------- single requester A ----------------
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234_5678;
    #1;
    check("sa_ardy", {31'd0, a_ready}, 32'd1);
    check("sa_brdy", {31'd0, b_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    check("sa_we",  {31'd0, rf_write}, 32'd1);
    check("sa_reg", {27'd0, rf_writeReg}, 32'd5);
    check("sa_dat", rf_writeData, 32'h1234_5678);
    tick();
    check("sa_we_off", {31'd0, rf_write}, 32'd0);
    check("sa_x5", rf_model[5], 32'h1234_5678);

    // ---------------- x0 drop by B (ptr now B) ----------------
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_00FF;
    #1;
    check("x0_brdy", {31'd0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    check("x0_we", {31'd0, rf_write}, 32'd0);
    tick();
    check("x0_read", rf_model[0], 32'd0);
    // ptr should now favour A under contention
    a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h0000_0099;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h0000_0010;
    #1;
    check("x0_ptr_ardy", {31'd0, a_ready}, 32'd1);
    check("x0_ptr_brdy", {31'd0, b_ready}, 32'd0);
    tick();
    check("x0_ptr_reg", {27'd0, rf_writeReg}, 32'd9);
    check("mr_pre_we",  {31'd0, rf_write}, 32'd1);

    // ---------------- mid-run reset during contended burst ----------------
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_we",   {31'd0, rf_write}, 32'd0);
    check("mr_done", {31'd0, init_done}, 32'd0);
    check("mr_ardy", {31'd0, a_ready}, 32'd0);
    check("mr_brdy", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear(0);  // both valids still held; first grant after clear is A
    tick();
    check("mr_first_reg", {27'd0, rf_writeReg}, 32'd9);
    check("mr_first_we",  {31'd0, rf_write}, 32'd1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();

    // ---------------- early request during clear ----------------
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_clear(10);
    tick();  // P32: transfer
    a_valid = 1'b0;
    check("er_we",  {31'd0, rf_write}, 32'd1);
    check("er_reg", {27'd0, rf_writeReg}, 32'd7);
    check("er_dat", rf_writeData, 32'h0000_0055);
    tick();  // P33: committed
    check("er_x7", rf_model[7], 32'h0000_0055);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32-entry register file. After reset it sequences a clear of x1..x31 to zero. It then shares the register file's single write port between two writeback requesters, A (ALU) and B (load), using round-robin arbitration with valid/ready handshakes. It drives the register file's `writeReg`, `writeData` and `write` inputs from registered outputs. Read ports are not touched.

## Interface
- `BUS_WIDTH`, 32: width of write data.
- `clk` in 1: rising-edge clock shared with the register file.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `a_valid` in 1: requester A has a write pending.
- `a_ready` out 1: A's request is accepted this cycle.
- `a_addr` in 5: destination register for A.
- `a_data` in BUS_WIDTH: write data for A.
- `b_valid` in 1: requester B has a write pending.
- `b_ready` out 1: B's request is accepted this cycle.
- `b_addr` in 5: destination register for B.
- `b_data` in BUS_WIDTH: write data for B.
- `rf_writeReg` out 5: connects to regfile `writeReg`.
- `rf_writeData` out BUS_WIDTH: connects to regfile `writeData`.
- `rf_write` out 1: connects to regfile `write`.
- `init_done` out 1: clear sequence complete; arbiter is servicing requests.

## Operation
- **States:** two states, CLEAR and RUN. Reset enters CLEAR.
- **CLEAR:**
  - A 5-bit counter `cnt` starts at 1.
  - Each posedge registers `rf_write`=1, `rf_writeReg`=`cnt`, `rf_writeData`=0, then increments `cnt`.
  - The posedge that issues `cnt`=31 also moves to RUN and sets `init_done`=1.
  - x0 is never written.
  - `a_ready`=`b_ready`=0 throughout.
- **RUN, grant logic (combinational):**
  - A only valid: `a_ready`=1.
  - B only valid: `b_ready`=1.
  - Both valid: the side indicated by the priority pointer `ptr` is granted.
  - Neither valid: both readies 0.
  - At most one ready is high in any cycle.
- **Handshake:**
  - A transfer occurs on a posedge with valid && ready.
  - The requester must hold valid, addr and data stable until its transfer.
  - Valid must not depend on ready.
- **Pointer:**
  - After any grant, `ptr` points to the non-granted side.
  - `ptr` is unchanged on idle cycles.
  - Reset value of `ptr` is A.
- **Output registers:**
  - A transfer with addr≠0 registers `rf_write`=1 and the granted addr/data.
  - A transfer with addr=0 completes the handshake but registers `rf_write`=0; the write is dropped.
  - No transfer registers `rf_write`=0. `rf_writeReg` and `rf_writeData` hold their last values.
- **Throughput:** one write per cycle sustained. There are no internal buffers, so back-pressure exists only for the losing requester.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n` low): `rf_write`=0, `rf_writeReg`=0, `rf_writeData`=0, `init_done`=0, `a_ready`=`b_ready`=0, state=CLEAR, `cnt`=1, `ptr`=A.
- **Clear sequence:**
  - Counting posedges after `rst_n` rises as P1, P2, …, posedge Pk registers a write of x`k`, for k=1..31.
  - The regfile commits x`k` at P(k+1).
  - `init_done` and RUN are active from P31 onward.
  - The first transfer can occur at P32; its write commits at P33.
- **Write latency:** a transfer at posedge N drives `rf_write` during cycle N..N+1, and the regfile commits at posedge N+1. A same-cycle read of that address returns the new data through the regfile's write-first forwarding.
- **Reset mid-operation:**
  - Any in-flight `rf_write` is killed immediately.
  - A pending request is not accepted and must be re-presented.
  - The full 31-cycle clear reruns after release.
- **Requests during CLEAR:** held with ready=0, and accepted no earlier than P32.

## Test plan
- **Reset/clear:** release `rst_n` with both valids low. Expect `rf_write`=1 for exactly 31 consecutive cycles with `rf_writeReg`=1..31 and data 0, then `init_done`=1. A regfile read of every register returns 0.
- **Single requester:** in RUN, A presents addr 5, data 0x12345678 for one cycle. Expect `a_ready`=1, then `rf_write`=1, `rf_writeReg`=5, `rf_writeData`=0x12345678 the next cycle. A read of x5 returns 0x12345678.
- **Contention:** A (addr 3, 0xAAAA0003) and B (addr 4, 0xBBBB0004) are both held valid, with `ptr`=A after reset. Expect grants A,B,A,B; `rf_writeReg` sequence 3,4,3,4; never both readies high.
- **x0 drop:** B writes addr 0, data 0xFF. Expect `b_ready`=1, `rf_write` stays 0, x0 reads 0, and `ptr` moves to A.
- **Early request:** `a_valid` is asserted 10 cycles after reset release with addr 7, data 0x55. Expect `a_ready`=0 until `init_done`, a transfer at P32, and x7 reading 0x55 after P33.
- **Mid-run reset:** pull `rst_n` low during a contended burst. Expect `rf_write`, `init_done` and both readies 0 without waiting for a clock edge. After release, expect a fresh 31-write clear and first grant to A under contention.
